// File: rtl/alu_adder_pipe.sv
// Segmented, pipelined add/subtract unit with Z/V/N flags and valid/ready backpressure.
// Define ALU_ADDER_PIPE_SAT_EN to saturate S whenever V is set.
module alu_adder_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEG   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [5:0]       ALUFun,
    input  logic             Sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Z,
    output logic             V,
    output logic             N
);
    localparam int L = int'(WIDTH / SEG);
    localparam int unsigned MSB = WIDTH - 1;

    // Per-stage state: operands travel whole, result fills in one segment per stage.
    logic             vld_q [L];
    logic [WIDTH-1:0] a_q   [L];
    logic [WIDTH-1:0] bp_q  [L];
    logic [WIDTH-1:0] s_q   [L];
    logic             c_q   [L];
    logic             sub_q [L];
    logic             sgn_q [L];

    logic             vld_d [L];
    logic [WIDTH-1:0] a_d   [L];
    logic [WIDTH-1:0] bp_d  [L];
    logic [WIDTH-1:0] s_d   [L];
    logic             c_d   [L];
    logic             sub_d [L];
    logic             sgn_d [L];

    logic             en;
    logic [WIDTH-1:0] bp0;
    logic [SEG:0]     sum;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] s_fin;
    logic             vs;
    logic             v_d;
    logic             n_d;
    logic             z_d;
    logic             z_q;
    logic             v_q;
    logic             n_q;
    logic             unused_fun;

    assign unused_fun = ^ALUFun[5:1];

    assign en        = !out_valid || out_ready;
    assign in_ready  = en && !flush;
    assign out_valid = vld_q[L-1];
    assign S         = s_q[L-1];
    assign Z         = z_q;
    assign V         = v_q;
    assign N         = n_q;

    always_comb begin
        bp0 = ALUFun[0] ? ~B : B;
        sum = {1'b0, A[SEG-1:0]} + {1'b0, bp0[SEG-1:0]} + {{SEG{1'b0}}, ALUFun[0]};
        vld_d[0] = in_valid;
        a_d[0]   = A;
        bp_d[0]  = bp0;
        s_d[0]   = '0;
        s_d[0][SEG-1:0] = sum[SEG-1:0];
        c_d[0]   = sum[SEG];
        sub_d[0] = ALUFun[0];
        sgn_d[0] = Sign;
        for (int k = 1; k < L; k++) begin
            sum = {1'b0, a_q[k-1][k*SEG +: SEG]} + {1'b0, bp_q[k-1][k*SEG +: SEG]}
                + {{SEG{1'b0}}, c_q[k-1]};
            vld_d[k] = vld_q[k-1];
            a_d[k]   = a_q[k-1];
            bp_d[k]  = bp_q[k-1];
            s_d[k]   = s_q[k-1];
            s_d[k][k*SEG +: SEG] = sum[SEG-1:0];
            c_d[k]   = sum[SEG];
            sub_d[k] = sub_q[k-1];
            sgn_d[k] = sgn_q[k-1];
        end
    end

    // Flags are resolved in the last stage from the complete raw sum and final carry.
    always_comb begin
        raw = s_d[L-1];
        vs  = (a_d[L-1][MSB] == bp_d[L-1][MSB]) && (raw[MSB] != a_d[L-1][MSB]);
        if (sgn_d[L-1]) begin
            v_d = vs;
            n_d = raw[MSB] ^ vs;
        end else if (!sub_d[L-1]) begin
            v_d = c_d[L-1];
            n_d = 1'b0;
        end else begin
            v_d = !c_d[L-1];
            n_d = !c_d[L-1];
        end
        s_fin = raw;
`ifdef ALU_ADDER_PIPE_SAT_EN
        if (v_d) begin
            if (sgn_d[L-1]) begin
                s_fin = n_d ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                s_fin = sub_d[L-1] ? '0 : '1;
            end
        end
`endif
        z_d = (s_fin == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < L; k++) begin
                vld_q[k] <= 1'b0;
                a_q[k]   <= '0;
                bp_q[k]  <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                sub_q[k] <= 1'b0;
                sgn_q[k] <= 1'b0;
            end
            z_q <= 1'b0;
            v_q <= 1'b0;
            n_q <= 1'b0;
        end else begin
            if (flush) begin
                for (int k = 0; k < L; k++) vld_q[k] <= 1'b0;
            end else if (en) begin
                for (int k = 0; k < L; k++) vld_q[k] <= vld_d[k];
            end
            if (en) begin
                for (int k = 0; k < L; k++) begin
                    a_q[k]   <= a_d[k];
                    bp_q[k]  <= bp_d[k];
                    s_q[k]   <= (k == L - 1) ? s_fin : s_d[k];
                    c_q[k]   <= c_d[k];
                    sub_q[k] <= sub_d[k];
                    sgn_q[k] <= sgn_d[k];
                end
                z_q <= z_d;
                v_q <= v_d;
                n_q <= n_d;
            end
        end
    end

endmodule
